// File: rtl/rx_rs_blk_framer.sv
// rx_rs_blk_framer
// Delineates RS codewords in the symbol stream from the block-sync stage.
// It forwards each codeword to the RS decoder with start/end/sof markers.
// Malformed codewords are cut short with a one-cycle abort pulse.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_data             symbol from block sync
//   i_sof              start-of-frame marker aligned with i_data
//   i_rs_data_symbol   i_data is an RS data symbol
//   i_rs_check_symbol  i_data is an RS check symbol
//   i_comma_aligned    link alignment status
//   o_data, o_valid    registered symbol to the decoder (o_data holds when idle)
//   o_blk_start        o_data is codeword symbol 0
//   o_blk_end          o_data is codeword symbol RS_N-1
//   o_blk_sof          the codeword began a frame (qualified by o_blk_start)
//   o_blk_abort        decoder must discard the partial codeword
//   o_err_cnt          saturating aborted-block count (only with RX_RS_BLK_STAT_EN)
//
// Build option: define RX_RS_BLK_STAT_EN to add the o_err_cnt port and its counter.

`ifndef RS_N
`define RS_N 15
`endif
`ifndef RS_K
`define RS_K 11
`endif

module rx_rs_blk_framer #(
  parameter int RS_N = `RS_N,
  parameter int RS_K = `RS_K
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_sof,
  input  logic        i_rs_data_symbol,
  input  logic        i_rs_check_symbol,
  input  logic        i_comma_aligned,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_blk_start,
  output logic        o_blk_end,
  output logic        o_blk_sof,
  output logic        o_blk_abort
`ifdef RX_RS_BLK_STAT_EN
  ,
  output logic [15:0] o_err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

  localparam logic [9:0] K_LAST = 10'(RS_K - 1);
  localparam logic [9:0] N_LAST = 10'(RS_N - 1);

  state_t     state, nxt_state;
  logic [9:0] cnt, nxt_cnt;
  logic [7:0] nxt_data;
  logic       nxt_valid, nxt_start, nxt_end, nxt_sof, nxt_abort;
  logic       in_data, in_check;

  // A symbol counts as data or check only when exactly one flag is set;
  // both set falls through to the protocol-error path.
  assign in_data  = i_rs_data_symbol & ~i_rs_check_symbol;
  assign in_check = i_rs_check_symbol & ~i_rs_data_symbol;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_blk_start <= 1'b0;
      o_blk_end   <= 1'b0;
      o_blk_sof   <= 1'b0;
      o_blk_abort <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      o_data      <= nxt_data;
      o_valid     <= nxt_valid;
      o_blk_start <= nxt_start;
      o_blk_end   <= nxt_end;
      o_blk_sof   <= nxt_sof;
      o_blk_abort <= nxt_abort;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_data  = o_data;
    nxt_valid = 1'b0;
    nxt_start = 1'b0;
    nxt_end   = 1'b0;
    nxt_sof   = 1'b0;
    nxt_abort = 1'b0;

    if (!i_comma_aligned) begin
      // Loss of alignment kills any codeword in flight.
      nxt_state = IDLE;
      nxt_cnt   = '0;
      nxt_abort = (state != IDLE);
    end else begin
      case (state)
        IDLE: begin
          // A lone check symbol here is noise and is dropped silently.
          if (in_data) begin
            nxt_data  = i_data;
            nxt_valid = 1'b1;
            nxt_start = 1'b1;
            nxt_sof   = i_sof;
            nxt_cnt   = 10'd1;
            nxt_state = DATA;
          end
        end
        DATA, CHECK: begin
          if (in_data && i_sof) begin
            // A new frame preempts the current codeword: abort it and start
            // the new one in the same output cycle.
            nxt_abort = 1'b1;
            nxt_data  = i_data;
            nxt_valid = 1'b1;
            nxt_start = 1'b1;
            nxt_sof   = 1'b1;
            nxt_cnt   = 10'd1;
            nxt_state = DATA;
          end else if (state == DATA && in_data) begin
            nxt_data  = i_data;
            nxt_valid = 1'b1;
            nxt_cnt   = cnt + 10'd1;
            if (cnt == K_LAST)
              nxt_state = CHECK;
          end else if (state == CHECK && in_check) begin
            nxt_data  = i_data;
            nxt_valid = 1'b1;
            if (cnt == N_LAST) begin
              nxt_end   = 1'b1;
              nxt_cnt   = '0;
              nxt_state = IDLE;
            end else begin
              nxt_cnt = cnt + 10'd1;
            end
          end else begin
            // Gap, both flags, or wrong symbol type for this phase.
            nxt_abort = 1'b1;
            nxt_cnt   = '0;
            nxt_state = IDLE;
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

`ifdef RX_RS_BLK_STAT_EN
  // Counts alongside the abort pulse so both appear in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_err_cnt <= 16'h0000;
    else if (nxt_abort && o_err_cnt != 16'hFFFF)
      o_err_cnt <= o_err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rx_rs_blk_framer.sv
// tb_rx_rs_blk_framer
// Self-checking bench for rx_rs_blk_framer with RS_N=15, RS_K=11.
// Every driven symbol pushes its expected registered output onto a scoreboard
// queue; the next cycle the scenario task pops it and compares.

module tb_rx_rs_blk_framer;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       start;
    logic       endf;
    logic       sof;
    logic       abort;
  } out_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_data = 8'h00;
  logic        i_sof = 1'b0;
  logic        i_rs_data_symbol = 1'b0;
  logic        i_rs_check_symbol = 1'b0;
  logic        i_comma_aligned = 1'b1;
  logic [7:0]  o_data;
  logic        o_valid, o_blk_start, o_blk_end, o_blk_sof, o_blk_abort;
`ifdef RX_RS_BLK_STAT_EN
  logic [15:0] o_err_cnt;
`endif

  out_t       sb_q[$];
  out_t       got, exp;
  logic [7:0] exp_last = 8'h00;
  int         n_checks = 0;
  int         n_errors = 0;

  rx_rs_blk_framer #(.RS_N(15), .RS_K(11)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_data(i_data),
    .i_sof(i_sof),
    .i_rs_data_symbol(i_rs_data_symbol),
    .i_rs_check_symbol(i_rs_check_symbol),
    .i_comma_aligned(i_comma_aligned),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_blk_start(o_blk_start),
    .o_blk_end(o_blk_end),
    .o_blk_sof(o_blk_sof),
    .o_blk_abort(o_blk_abort)
`ifdef RX_RS_BLK_STAT_EN
    ,
    .o_err_cnt(o_err_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Drive one input cycle, queue its expected output, and advance to #1 after
  // the capturing edge. o_data is expected to hold when nothing is valid.
  task automatic drive_push(input logic rst, input logic [7:0] d, input logic sof,
                            input logic dsym, input logic csym, input logic ca,
                            input logic ev, input logic es, input logic ee,
                            input logic esof, input logic eab);
    i_rst = rst;
    i_data = d;
    i_sof = sof;
    i_rs_data_symbol = dsym;
    i_rs_check_symbol = csym;
    i_comma_aligned = ca;
    if (rst) exp_last = 8'h00;
    else if (ev) exp_last = d;
    sb_q.push_back({exp_last, ev, es, ee, esof, eab});
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive_push(1, 8'hA5, 1, 1, 0, 1, 0, 0, 0, 0, 0);
      got = {o_data, o_valid, o_blk_start, o_blk_end, o_blk_sof, o_blk_abort};
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++; $display("[TB] FAIL reset step %0d: scoreboard empty", i);
      end else begin
        exp = sb_q.pop_front();
        if (got !== exp) begin
          n_errors++; $display("[TB] FAIL reset step %0d: got %h expected %h", i, got, exp);
        end
      end
    end
`ifdef RX_RS_BLK_STAT_EN
    n_checks++;
    if (o_err_cnt !== 16'd0) begin
      n_errors++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", o_err_cnt);
    end
`endif
  endtask

  task automatic test_single_codeword();
    for (int i = 0; i < 16; i++) begin
      if (i < 11)      drive_push(0, 8'(i), i == 0, 1, 0, 1, 1, i == 0, 0, i == 0, 0);
      else if (i < 15) drive_push(0, 8'(8'hF0 + i - 11), 0, 0, 1, 1, 1, 0, i == 14, 0, 0);
      else             drive_push(0, 8'h55, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      got = {o_data, o_valid, o_blk_start, o_blk_end, o_blk_sof, o_blk_abort};
      n_checks++;
      exp = sb_q.pop_front();
      if (got !== exp) begin
        n_errors++; $display("[TB] FAIL single step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      int j;
      j = i % 15;
      if (j < 11) drive_push(0, 8'(8'h40 + i), i == 0, 1, 0, 1, 1, j == 0, 0, i == 0, 0);
      else        drive_push(0, 8'(8'hC0 + i), 0, 0, 1, 1, 1, 0, j == 14, 0, 0);
      got = {o_data, o_valid, o_blk_start, o_blk_end, o_blk_sof, o_blk_abort};
      n_checks++;
      exp = sb_q.pop_front();
      if (got !== exp) begin
        n_errors++; $display("[TB] FAIL back_to_back step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_codeword();
    for (int i = 0; i < 12; i++) begin
      if (i < 9)       drive_push(0, 8'(8'h60 + i), i == 0, 1, 0, 1, 1, i == 0, 0, i == 0, 0);
      else if (i == 9) drive_push(1, 8'h69, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      else if (i == 10) drive_push(0, 8'h77, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      else             drive_push(0, 8'h78, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      got = {o_data, o_valid, o_blk_start, o_blk_end, o_blk_sof, o_blk_abort};
      n_checks++;
      exp = sb_q.pop_front();
      if (got !== exp) begin
        n_errors++; $display("[TB] FAIL reset_mid step %0d: got %h expected %h", i, got, exp);
      end
    end
`ifdef RX_RS_BLK_STAT_EN
    n_checks++;
    if (o_err_cnt !== 16'd0) begin
      n_errors++; $display("[TB] FAIL reset_mid_err_cnt: got %0d expected 0", o_err_cnt);
    end
`endif
  endtask

  task automatic test_comma_loss();
    for (int i = 0; i < 23; i++) begin
      if (i < 5)       drive_push(0, 8'(8'h10 + i), i == 0, 1, 0, 1, 1, i == 0, 0, i == 0, 0);
      else if (i < 8)  drive_push(0, 8'(8'h10 + i), 0, 1, 0, 0, 0, 0, 0, 0, i == 5);
      else if (i < 19) drive_push(0, 8'(8'h80 + i), i == 8, 1, 0, 1, 1, i == 8, 0, i == 8, 0);
      else             drive_push(0, 8'(8'hD0 + i), 0, 0, 1, 1, 1, 0, i == 22, 0, 0);
      got = {o_data, o_valid, o_blk_start, o_blk_end, o_blk_sof, o_blk_abort};
      n_checks++;
      exp = sb_q.pop_front();
      if (got !== exp) begin
        n_errors++; $display("[TB] FAIL comma_loss step %0d: got %h expected %h", i, got, exp);
      end
    end
`ifdef RX_RS_BLK_STAT_EN
    n_checks++;
    if (o_err_cnt !== 16'd1) begin
      n_errors++; $display("[TB] FAIL comma_err_cnt: got %0d expected 1", o_err_cnt);
    end
`endif
  endtask

  task automatic test_check_in_data();
    for (int i = 0; i < 23; i++) begin
      int j;
      j = i - 8;
      if (i < 7)       drive_push(0, 8'(8'h20 + i), i == 0, 1, 0, 1, 1, i == 0, 0, i == 0, 0);
      else if (i == 7) drive_push(0, 8'hEE, 0, 0, 1, 1, 0, 0, 0, 0, 1);
      else if (j < 11) drive_push(0, 8'(8'h30 + j), 0, 1, 0, 1, 1, j == 0, 0, 0, 0);
      else             drive_push(0, 8'(8'hE0 + j), 0, 0, 1, 1, 1, 0, j == 14, 0, 0);
      got = {o_data, o_valid, o_blk_start, o_blk_end, o_blk_sof, o_blk_abort};
      n_checks++;
      exp = sb_q.pop_front();
      if (got !== exp) begin
        n_errors++; $display("[TB] FAIL check_in_data step %0d: got %h expected %h", i, got, exp);
      end
    end
`ifdef RX_RS_BLK_STAT_EN
    n_checks++;
    if (o_err_cnt !== 16'd2) begin
      n_errors++; $display("[TB] FAIL check_in_data_err_cnt: got %0d expected 2", o_err_cnt);
    end
`endif
  endtask

  task automatic test_sof_in_check();
    for (int i = 0; i < 27; i++) begin
      int j;
      j = i - 12;
      if (i < 11)       drive_push(0, 8'(8'h50 + i), i == 0, 1, 0, 1, 1, i == 0, 0, i == 0, 0);
      else if (i == 11) drive_push(0, 8'hB0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
      else if (i == 12) drive_push(0, 8'hA0, 1, 1, 0, 1, 1, 1, 0, 1, 1);
      else if (j < 11)  drive_push(0, 8'(8'hA0 + j), 0, 1, 0, 1, 1, 0, 0, 0, 0);
      else              drive_push(0, 8'(8'hB0 + j), 0, 0, 1, 1, 1, 0, j == 14, 0, 0);
      got = {o_data, o_valid, o_blk_start, o_blk_end, o_blk_sof, o_blk_abort};
      n_checks++;
      exp = sb_q.pop_front();
      if (got !== exp) begin
        n_errors++; $display("[TB] FAIL sof_in_check step %0d: got %h expected %h", i, got, exp);
      end
    end
`ifdef RX_RS_BLK_STAT_EN
    n_checks++;
    if (o_err_cnt !== 16'd3) begin
      n_errors++; $display("[TB] FAIL sof_in_check_err_cnt: got %0d expected 3", o_err_cnt);
    end
`endif
  endtask

  initial begin
    @(posedge i_clk);
    #1;
    test_reset();
    test_single_codeword();
    test_back_to_back();
    test_reset_mid_codeword();
    test_comma_loss();
    test_check_in_data();
    test_sof_in_check();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
